// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, forward S-box, round constants and expander state type
package aes_pkg;

    localparam int NK = 8;
    localparam int NR = 14;
    localparam int NW = 4 * (NR + 1);

    // Entry 0 sits in the most significant byte so the table reads in natural order.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [2:0] n);
        logic [7:0] r;
        case (n)
            3'd1:    r = 8'h01;
            3'd2:    r = 8'h02;
            3'd3:    r = 8'h04;
            3'd4:    r = 8'h08;
            3'd5:    r = 8'h10;
            3'd6:    r = 8'h20;
            3'd7:    r = 8'h40;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_subword.sv
// rtl/aes_subword.sv - combinational SubWord: forward S-box applied to each byte of a word
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign word_out[8*b +: 8] = sbox_fwd(word_in[8*b +: 8]);
    end

endmodule

// File: rtl/aes256_key_expander.sv
// rtl/aes256_key_expander.sv - AES-256 key schedule, one word per clock, round keys served by index
module aes256_key_expander
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic [255:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  idx_q;
    logic [31:0] w_q [NW];

    logic        accept;
    logic        last_word;
    logic [31:0] prev_word;
    logic [31:0] rot_word;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] mix_word;
    logic [31:0] new_word;
    logic [5:0]  rk_base;

    assign accept    = key_valid && key_ready;
    assign last_word = (idx_q == 6'(NW - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXPAND;
            EXPAND:  if (last_word) state_d = DONE;
            DONE:    if (accept) state_d = EXPAND;
            default: state_d = IDLE;
        endcase
    end

    // keys_valid falls on the accepting edge of a rekey because the state leaves DONE there.
    always_comb begin
        key_ready  = 1'b0;
        busy       = 1'b0;
        keys_valid = 1'b0;
        case (state_q)
            IDLE:    key_ready = 1'b1;
            EXPAND:  busy = 1'b1;
            DONE: begin
                key_ready  = 1'b1;
                keys_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Words are little-endian in bytes, so RotWord is a right rotate and Rcon lands in byte 0.
    assign prev_word = w_q[idx_q - 6'd1];
    assign rot_word  = {prev_word[7:0], prev_word[31:8]};
    assign sub_in    = (idx_q[2:0] == 3'd0) ? rot_word : prev_word;

    aes_subword u_subword (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    always_comb begin
        case (idx_q[2:0])
            3'd0:    mix_word = sub_out ^ {24'h000000, rcon(idx_q[5:3])};
            3'd4:    mix_word = sub_out;
            default: mix_word = prev_word;
        endcase
    end

    assign new_word = w_q[idx_q - 6'd8] ^ mix_word;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q <= '0;
        end else if (accept) begin
            idx_q <= 6'(NK);
        end else if (state_q == EXPAND && !last_word) begin
            idx_q <= idx_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int n = 0; n < NW; n++) begin
                w_q[n] <= '0;
            end
        end else if (accept) begin
            for (int j = 0; j < NK; j++) begin
                w_q[j] <= key_in[32*j +: 32];
            end
        end else if (state_q == EXPAND) begin
            w_q[idx_q] <= new_word;
        end
    end

    assign rk_base = {rk_addr, 2'b00};

    always_comb begin
        rk_data = '0;
        if (rk_addr < 4'(NR + 1)) begin
            rk_data = {w_q[rk_base + 6'd3], w_q[rk_base + 6'd2],
                       w_q[rk_base + 6'd1], w_q[rk_base]};
        end
    end

endmodule

// File: tb/tb_aes256_key_expander.sv
// tb/tb_aes256_key_expander.sv - directed self-checking bench for aes256_key_expander
module tb_aes256_key_expander;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [255:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rk_addr = '0;
    logic [127:0] rk_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_w [0:59];

    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes256_key_expander dut (
        .clk        (clk),
        .resetn     (resetn),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rev256(input logic [255:0] v);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = v[8*(31-k) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] rev128(input logic [127:0] v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = v[8*(15-k) +: 8];
        return r;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its algebraic definition: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        if (x != 8'h00)
            for (int c = 1; c < 256; c++)
                if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] sub_word_be(input logic [31:0] t);
        return {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
    endfunction

    // Model works in FIPS big-endian word order.
    task automatic compute_model(input logic [255:0] fips_key);
        logic [31:0] t;
        for (int j = 0; j < 8; j++) model_w[j] = fips_key[255 - 32*j -: 32];
        for (int i = 8; i < 60; i++) begin
            t = model_w[i-1];
            if (i % 8 == 0) begin
                t = sub_word_be({t[23:0], t[31:24]});
                t = t ^ {8'h01 << (i/8 - 1), 24'h000000};
            end else if (i % 8 == 4) begin
                t = sub_word_be(t);
            end
            model_w[i] = model_w[i-8] ^ t;
        end
    endtask

    function automatic logic [127:0] model_rk(input int r);
        return rev128({model_w[4*r], model_w[4*r+1], model_w[4*r+2], model_w[4*r+3]});
    endfunction

    task automatic read_rk(input int r, output logic [127:0] d);
        rk_addr = 4'(r);
        #1;
        d = rk_data;
    endtask

    task automatic load_key(input logic [255:0] fips_key);
        @(negedge clk);
        key_in    = rev256(fips_key);
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_keys(output int n, output bit bad);
        n = 0;
        bad = 1'b0;
        while (!keys_valid && n < 200) begin
            if (key_ready || !busy) bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic sweep(input string tag);
        logic [127:0] d;
        for (int r = 0; r < 15; r++) begin
            read_rk(r, d);
            check($sformatf("%s rk%0d", tag, r), d, model_rk(r));
        end
    endtask

    initial begin
        int n;
        bit bad;
        logic [127:0] d;

        #1;
        check("reset key_ready", 128'(key_ready), 128'd1);
        check("reset busy", 128'(busy), 128'd0);
        check("reset keys_valid", 128'(keys_valid), 128'd0);
        read_rk(0, d);
        check("reset rk0", d, '0);
        @(negedge clk);
        resetn = 1'b1;

        // FIPS-197 C.3 key
        compute_model(KEY_C3);
        load_key(KEY_C3);
        wait_keys(n, bad);
        check("c3 latency", 128'(n), 128'd52);
        check("c3 ready during expand", 128'(bad), 128'd0);
        read_rk(0, d);
        check("c3 rk0", d, rev128(128'h000102030405060708090a0b0c0d0e0f));
        read_rk(1, d);
        check("c3 rk1", d, rev128(128'h101112131415161718191a1b1c1d1e1f));
        read_rk(2, d);
        check("c3 rk2", d, rev128(128'ha573c29fa176c498a97fce93a572c09c));
        read_rk(14, d);
        check("c3 rk14", d, rev128(128'h24fc79ccbf0979e9371ac23c6d68de36));
        sweep("c3");
        read_rk(15, d);
        check("c3 rk15", d, '0);

        // Rekey from DONE with A.3 key, plus an ignored load request mid-expansion
        compute_model(KEY_A3);
        load_key(KEY_A3);
        check("rekey keys_valid drop", 128'(keys_valid), 128'd0);
        check("rekey busy", 128'(busy), 128'd1);
        repeat (10) @(posedge clk);
        #2;
        check("busy key_ready", 128'(key_ready), 128'd0);
        key_in    = rev256(KEY_C3);
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        read_rk(15, d);
        check("expand rk15", d, '0);
        wait_keys(n, bad);
        check("a3 latency", 128'(n + 11), 128'd52);
        check("a3 ready during expand", 128'(bad), 128'd0);
        read_rk(2, d);
        check("a3 w8", 128'(d[31:0]), 128'(32'h1154a39b));
        read_rk(14, d);
        check("a3 w59", 128'(d[127:96]), 128'(32'h1e636c70));
        sweep("a3");
        read_rk(15, d);
        check("a3 rk15", d, '0);

        // Reset in the middle of an expansion
        compute_model(KEY_C3);
        load_key(KEY_C3);
        repeat (30) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("midreset key_ready", 128'(key_ready), 128'd1);
        check("midreset busy", 128'(busy), 128'd0);
        check("midreset keys_valid", 128'(keys_valid), 128'd0);
        for (int r = 0; r < 16; r++) begin
            read_rk(r, d);
            check($sformatf("midreset rk%0d", r), d, '0);
        end
        @(negedge clk);
        resetn = 1'b1;
        load_key(KEY_C3);
        wait_keys(n, bad);
        check("reload latency", 128'(n), 128'd52);
        read_rk(2, d);
        check("reload rk2", d, rev128(128'ha573c29fa176c498a97fce93a572c09c));
        read_rk(14, d);
        check("reload rk14", d, rev128(128'h24fc79ccbf0979e9371ac23c6d68de36));
        sweep("reload");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes256_key_expander.md
Name: aes256_key_expander

Overview:
- Upstream key source for the AES-256 encryption core.
- Accepts one 256-bit cipher key and iteratively expands it into 60 32-bit words, computing one word per clock.
- Holds the resulting 15 round keys and serves them by round index to the core's key-address/key-data port, with zero-latency read.
- Replaces the static key ROM: a new key can be loaded at run time.

Parameters:
- NK, 8, key length in 32-bit words (fixed for AES-256).
- NR, 14, number of rounds; NR+1 = 15 round keys.
- NW, 60, total expanded words = 4*(NR+1).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- key_in  in  256  cipher key; word j = key_in[32j+31:32j]; byte b of word j = key_in[32j+8b+7:32j+8b] (FIPS byte 4j+b)
- key_valid  in  1  load request; sampled only while key_ready=1
- key_ready  out  1  block can accept a key (IDLE or DONE)
- busy  out  1  expansion in progress
- keys_valid  out  1  all 15 round keys stored and stable
- rk_addr  in  4  round-key index 0..14 (driven by the core's key-address output)
- rk_data  out  128  round key rk_addr = {w[4r+3], w[4r+2], w[4r+1], w[4r]}; FIPS byte k of the round key at bits [8k+7:8k]

Behaviour:
- Reset values: key_ready=1, busy=0, keys_valid=0, state=IDLE, word counter=0, all stored words=0. rk_data therefore reads 0.
- States:
  - IDLE: key_ready=1.
    - key_valid=1 -> LOAD actions on this edge (E0): w[0..7] <= key_in, i <= 8, go to EXPAND.
  - EXPAND: busy=1, key_ready=0. Each edge writes w[i] and increments i. The edge that writes w[59] (E52) goes to DONE and sets keys_valid=1.
  - DONE: keys_valid=1, key_ready=1.
    - key_valid=1 -> same load as IDLE, keys_valid <= 0 on that edge, go to EXPAND.
- Latency: keys_valid rises 52 edges after the accepting edge E0 and is visible in the cycle after E52.
- Recurrence for i = 8..59, with t = w[i-1]:
  - i%8==0: t = SubWord(RotWord(t)) ^ Rcon(i/8).
  - i%8==4: t = SubWord(t).
  - Otherwise t is used unchanged.
  - w[i] = w[i-8] ^ t.
- RotWord in this byte order is {t[7:0], t[31:8]}.
- Rcon is XORed into byte 0 (bits [7:0]) only. Rcon(1..7) = 01,02,04,08,10,20,40.
- SubWord applies the AES forward S-box to each of the 4 bytes combinationally, in a single cycle.
- Read port:
  - rk_data is a combinational mux from the stored words, so the core sees the new key in the same cycle rk_addr changes.
  - rk_addr >= 15 -> rk_data = 0.
  - Reads during EXPAND return partially updated contents; consumers must gate on keys_valid.
- Boundary conditions:
  - key_valid while busy is ignored; no queuing.
  - key_valid held high in DONE starts a new expansion on every acceptance. The source must pulse it for one cycle.
  - key_in is sampled only at the accepting edge; later changes have no effect.
  - resetn low at any point, including mid-EXPAND, immediately returns all state and outputs to reset values. No partial keys survive.
  - Word counter range is 8..59 and never wraps; reaching 59 forces the exit to DONE.

Decomposition:
- Shared package aes_pkg:
  - Constants NK, NR, NW.
  - sbox_fwd function: 256-entry forward S-box, shared with the core's S-box ROM contents.
  - rcon table, entries 1..7.
  - State enum {IDLE, EXPAND, DONE}.
- One sub-module, aes_subword: 32-bit input -> 32-bit output, four sbox_fwd lookups, purely combinational.
- Storage is a 60x32 flop array.

Test Plan:
- FIPS-197 C.3 key 000102..1f, one-cycle key_valid -> keys_valid rises after edge E52.
  - rk_addr=0 -> bytes 000102..0f.
  - rk_addr=1 -> 101112..1f.
  - rk_addr=2 -> a573c29fa176c498a97fce93a572c09c.
  - rk_addr=14 -> 24fc79ccbf0979e9371ac23c6d68de36.
- FIPS-197 A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> w[8]=9ba35411 and w[59]=706c631e (FIPS byte order), checked via rk_addr 2 and 14.
- key_valid pulsed at cycle 10 of EXPAND with a different key_in -> ignored; final keys equal those of the first key; key_ready=0 throughout EXPAND.
- Rekey from DONE -> keys_valid drops on the accepting edge; new keys are valid 52 edges later; rk_addr=15 reads 0 at all times.
- resetn asserted at EXPAND cycle 30 -> outputs immediately at reset values, rk_data=0 for all addresses; a fresh load afterwards produces correct keys.
- Core-style sweep: rk_addr stepped 0..14 one value per cycle after keys_valid -> each rk_data matches the reference model in the same cycle.
